// File: rtl/seq_pattern_det.sv
// Serial pattern detector with a pattern and length loaded at run time.
// Supports overlapping or non-overlapping matches, and keeps a saturating match counter.
module seq_pattern_det #(
    parameter  int unsigned MAX_LEN = 8,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_data,
    input  logic               in_state_reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic [LW-1:0]      out_cur_state,
    output logic               out,
    output logic [CNT_W-1:0]   out_match_cnt,
    output logic               out_cnt_sat
);

    localparam logic [LW-1:0]    LEN_MAX = LW'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [LW-1:0]      state_q, state_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic [MAX_LEN-1:0] hist_acc;
    logic [LW-1:0]      fill_acc;
    logic [LW-1:0]      lim;
    logic [LW-1:0]      best;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] pat_sh;
    logic               match;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state logic
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        hist_acc = {hist_q[MAX_LEN-2:0], in_data};
        fill_acc = (fill_q == LEN_MAX) ? fill_q : fill_q + LW'(1);
        lim      = (fill_acc < len_q) ? fill_acc : len_q;
        mask     = '0;
        pat_sh   = '0;
        best     = '0;

        // Longest pattern prefix that ends the history; the ascending scan keeps the largest hit
        for (int unsigned k = 1; k <= MAX_LEN; k++) begin
            mask   = (MAX_LEN'(1) << k) - MAX_LEN'(1);
            pat_sh = pat_q >> (len_q - LW'(k));
            if ((LW'(k) <= lim) && (((hist_acc ^ pat_sh) & mask) == '0)) begin
                best = LW'(k);
            end
        end
        match = (len_q != '0) && (best == len_q);

        if (in_state_reset) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = '0;
        end else if (in_valid) begin
            hist_d  = hist_acc;
            fill_d  = fill_acc;
            state_d = best;
            out_d   = match;
            if (match) begin
                // Non-overlap restarts the search; stale history bits are masked by fill
                if (!ovl_q) begin
                    fill_d  = '0;
                    state_d = '0;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_d == CNT_MAX) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        out_cur_state = state_q;
        out           = out_q;
        out_match_cnt = cnt_q;
        out_cnt_sat   = sat_q;
    end

endmodule
